// File: rtl/trng_pkg.sv
// Shared types and helpers for the TRNG sampler: von Neumann pair state,
// default word width and the bit-counter width function.
package trng_pkg;

  typedef enum logic {
    VN_FIRST  = 1'b0,
    VN_SECOND = 1'b1
  } vn_state_e;

  localparam int DEFAULT_WIDTH = 8;

  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/trng_sync.sv
// STAGES-deep synchroniser for an asynchronous input. EDGE_EN=1 turns the
// output into a one-cycle pulse on each synchronised rising edge.
module trng_sync #(
  parameter int STAGES  = 2,
  parameter bit EDGE_EN = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] chain_q;
  logic              level_s;

  always_ff @(posedge clk) begin
    if (rst) begin
      chain_q <= '0;
    end else begin
      chain_q <= {chain_q[STAGES-2:0], d_i};
    end
  end

  assign level_s = chain_q[STAGES-1];

  if (EDGE_EN) begin : g_edge
    logic prev_q;

    always_ff @(posedge clk) begin
      if (rst) begin
        prev_q <= 1'b0;
      end else begin
        prev_q <= level_s;
      end
    end

    assign q_o = level_s & ~prev_q;
  end else begin : g_level
    assign q_o = level_s;
  end

endmodule

// File: rtl/trng_sampler.sv
// Samples a jittery oscillator on each divided-clock strobe, von Neumann
// debiases the raw bits and packs them into WIDTH-bit words over valid/ready.
// Define TRNG_REPCNT_EN to add the repetition-count health test.
module trng_sampler
  import trng_pkg::*;
#(
  parameter int WIDTH       = DEFAULT_WIDTH,
  parameter int SYNC_STAGES = 2,
  parameter int REP_LIMIT   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             sample_clk_in,
  input  logic             raw_bit_in,
  output logic [WIDTH-1:0] data_out,
  output logic             valid_out,
  input  logic             ready_in,
  output logic             overflow_out,
  output logic             health_fail_out
);

  localparam int             CW   = cnt_width(WIDTH);
  localparam logic [CW-1:0]  FULL = CW'(WIDTH);
  localparam logic [CW-1:0]  ONE  = CW'(1);

  logic strobe_s, s_bit_s, sample_s;
  logic accept_s, acc_bit_s, hf_s;
  logic complete_s, transfer_s;

  vn_state_e        state_q, state_d;
  logic             b0_q;
  logic [WIDTH-1:0] shreg_q, shreg_d, data_q, data_d;
  logic [CW-1:0]    count_q, count_d;
  logic             valid_q, valid_d, ovf_q, ovf_d;

  trng_sync #(.STAGES(SYNC_STAGES), .EDGE_EN(1'b1)) u_sync_clk (
    .clk(clk), .rst(rst), .d_i(sample_clk_in), .q_o(strobe_s)
  );

  trng_sync #(.STAGES(SYNC_STAGES), .EDGE_EN(1'b0)) u_sync_bit (
    .clk(clk), .rst(rst), .d_i(raw_bit_in), .q_o(s_bit_s)
  );

  assign sample_s = strobe_s & en;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= VN_FIRST;
      b0_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      b0_q    <= (sample_s && state_q == VN_FIRST) ? s_bit_s : b0_q;
    end
  end

  always_comb begin
    state_d = state_q;
    if (!en) begin
      state_d = VN_FIRST;
    end else if (sample_s) begin
      case (state_q)
        VN_FIRST:  state_d = VN_SECOND;
        VN_SECOND: state_d = VN_FIRST;
        default:   state_d = VN_FIRST;
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // Unequal pair accepts the first bit of the pair (01 -> 0, 10 -> 1).
  always_comb begin
    accept_s  = 1'b0;
    acc_bit_s = b0_q;
    case (state_q)
      VN_SECOND: accept_s = sample_s & (b0_q ^ s_bit_s);
      default:   accept_s = 1'b0;
    endcase
  end

  assign complete_s = (count_q == FULL);
  assign transfer_s = complete_s & (~valid_q | ready_in) & ~hf_s;

  always_comb begin
    shreg_d = shreg_q;
    count_d = count_q;
    data_d  = data_q;
    valid_d = valid_q;
    ovf_d   = ovf_q;
    if (transfer_s) begin
      data_d  = shreg_q;
      valid_d = 1'b1;
      count_d = '0;
    end else if (valid_q && ready_in) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
    // A bit arriving alongside a transfer starts the next word at count 1.
    if (accept_s) begin
      if (complete_s && !transfer_s) begin
        ovf_d = 1'b1;
      end else begin
        shreg_d = {shreg_q[WIDTH-2:0], acc_bit_s};
        count_d = transfer_s ? ONE : (count_q + ONE);
      end
    end else begin
      ovf_d = ovf_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shreg_q <= '0;
      count_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      shreg_q <= shreg_d;
      count_q <= count_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
    end
  end

`ifdef TRNG_REPCNT_EN
  localparam int            RW    = $clog2(REP_LIMIT + 1);
  localparam logic [RW-1:0] R_LIM = RW'(REP_LIMIT);
  localparam logic [RW-1:0] R_ONE = RW'(1);

  logic [RW-1:0] rep_q, rep_d;
  logic          last_q, hf_q, hf_d;

  // Run length of identical raw samples, saturating at the limit.
  always_comb begin
    rep_d = rep_q;
    hf_d  = hf_q;
    if (sample_s) begin
      if (rep_q == '0 || s_bit_s != last_q) begin
        rep_d = R_ONE;
      end else if (rep_q != R_LIM) begin
        rep_d = rep_q + R_ONE;
      end else begin
        rep_d = rep_q;
      end
      hf_d = hf_q | (rep_d == R_LIM);
    end else begin
      rep_d = rep_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rep_q  <= '0;
      last_q <= 1'b0;
      hf_q   <= 1'b0;
    end else begin
      rep_q  <= rep_d;
      last_q <= sample_s ? s_bit_s : last_q;
      hf_q   <= hf_d;
    end
  end

  assign hf_s = hf_q;
`else
  assign hf_s = 1'b0;
`endif

  assign data_out        = data_q;
  assign valid_out       = valid_q;
  assign overflow_out    = ovf_q;
  assign health_fail_out = hf_s;

endmodule
